// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset PC, constants and IF state encodings for the fetch stage.
package inst_fetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam int unsigned StallW      = 5;

  localparam logic [InstAddrBus-1:0] ResetPc  = 32'h0000_0000;
  localparam logic [InstBus-1:0]     ZeroWord = 32'h0000_0000;
  localparam logic                   True_v   = 1'b1;
  localparam logic                   False_v  = 1'b0;

  typedef enum logic [1:0] {
    IfIdle  = 2'd0,
    IfFetch = 2'd1,
    IfReady = 2'd2,
    IfDrop  = 2'd3
  } if_state_e;

endpackage

// File: rtl/inst_fetch_pc_gen.sv
// Program counter: holds pc, applies word-aligned redirects (highest priority) and +4 advance.
module pc_gen
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = ResetPc
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   redirect,
  input  logic [InstAddrBus-1:0] target,
  input  logic                   advance,
  output logic [InstAddrBus-1:0] pc,
  output logic [InstAddrBus-1:0] pc_nxt_c
);

  // Low target bits are dropped by alignment.
  logic [1:0] unused_target_lsb;
  assign unused_target_lsb = target[1:0];

  always_comb begin
    pc_nxt_c = pc;
    if (redirect) begin
      pc_nxt_c = {target[InstAddrBus-1:2], 2'b00};
    end else if (advance) begin
      pc_nxt_c = pc + InstAddrBus'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (rdy) begin
      pc <= pc_nxt_c;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: req/ack word fetch, holds the word for IF_ID, applies EX redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = ResetPc
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [StallW-1:0]      stall,
  input  logic                   br_taken,
  input  logic [InstAddrBus-1:0] br_target,
  output logic                   mem_req,
  output logic [InstAddrBus-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [InstBus-1:0]     mem_rdata,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   if_valid,
  output logic                   stall_req
);

  if_state_e              state;
  if_state_e              state_nxt;
  logic                   consume_c;
  logic [InstAddrBus-1:0] pc;
  logic [InstAddrBus-1:0] pc_nxt;

  // Only stall[0] concerns IF.
  logic [StallW-1:1] unused_stall;
  assign unused_stall = stall[StallW-1:1];

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .redirect (br_taken),
    .target   (br_target),
    .advance  (consume_c),
    .pc       (pc),
    .pc_nxt_c (pc_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IfIdle;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  // Redirect beats stall/consume; an unacked request must finish in DROP.
  always_comb begin
    state_nxt = state;
    consume_c = False_v;
    unique case (state)
      IfIdle: state_nxt = IfFetch;
      IfFetch: begin
        if (br_taken) begin
          state_nxt = mem_ack ? IfFetch : IfDrop;
        end else if (mem_ack) begin
          state_nxt = IfReady;
        end
      end
      IfReady: begin
        if (br_taken) begin
          state_nxt = IfFetch;
        end else if (!stall[0]) begin
          state_nxt = IfFetch;
          consume_c = True_v;
        end
      end
      IfDrop: begin
        if (mem_ack) begin
          state_nxt = IfFetch;
        end
      end
      default: state_nxt = IfIdle;
    endcase
  end

  // Outputs registered from next state; if_inst doubles as the fetch buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= False_v;
      mem_addr  <= RESET_PC;
      if_pc     <= '0;
      if_inst   <= ZeroWord;
      if_valid  <= False_v;
      stall_req <= True_v;
    end else if (rdy) begin
      mem_req   <= (state_nxt == IfFetch) || (state_nxt == IfDrop);
      if_valid  <= (state_nxt == IfReady);
      stall_req <= (state_nxt != IfReady);
      if (state_nxt == IfFetch) begin
        mem_addr <= pc_nxt;
      end
      if (state_nxt == IfReady) begin
        if_pc <= pc;
        if (state == IfFetch) begin
          if_inst <= mem_rdata;
        end
      end else begin
        if_pc   <= '0;
        if_inst <= ZeroWord;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed plus randomized bench for inst_fetch against a program-order reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [4:0]  stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stall_req;

  int checks   = 0;
  int failures = 0;
  int presented = 0;

  // Reference model: the pc of the next instruction IF must present or fetch.
  logic [31:0] exp_pc;
  bit          auto_mem;
  int          wait_cnt;
  int          lat_lo;
  int          lat_hi;

  logic        p_req, p_valid, p_rdy, p_fire;
  logic [31:0] p_addr, p_pc, p_inst;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_valid  (if_valid),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory controller model with random latency; frozen by rdy like the real one.
  task automatic drive_mem();
    if (rdy && mem_req) begin
      if (wait_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = word_of(mem_addr);
        wait_cnt  = $urandom_range(lat_hi, lat_lo);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wait_cnt--;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_addr"},  mem_addr,       32'h0);
    chk({tag, "_if_pc"},     if_pc,          32'h0);
    chk({tag, "_if_inst"},   if_inst,        32'h0);
    chk({tag, "_if_valid"},  32'(if_valid),  32'd0);
    chk({tag, "_stall_req"}, 32'(stall_req), 32'd1);
  endtask

  task automatic verify();
    chk("stall_req", 32'(stall_req), 32'(!if_valid));
    if (if_valid) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_inst", if_inst, word_of(exp_pc));
      chk("req_in_ready", 32'(mem_req), 32'd0);
    end else begin
      chk("bubble_pc", if_pc, 32'h0);
      chk("bubble_inst", if_inst, 32'h0);
    end
    if (!p_rdy) begin
      chk("frz_valid", 32'(if_valid), 32'(p_valid));
      chk("frz_pc", if_pc, p_pc);
      chk("frz_inst", if_inst, p_inst);
      chk("frz_req", 32'(mem_req), 32'(p_req));
      chk("frz_addr", mem_addr, p_addr);
    end
    if (p_req && !p_fire) begin
      chk("req_held", 32'(mem_req), 32'd1);
      chk("addr_stable", mem_addr, p_addr);
    end else if (mem_req) begin
      chk("req_addr", mem_addr, exp_pc);
    end
  endtask

  // One clock: snapshot, edge, model update from sampled inputs, check at negedge.
  task automatic tick();
    if (auto_mem) drive_mem();
    p_req   = mem_req;
    p_addr  = mem_addr;
    p_valid = if_valid;
    p_pc    = if_pc;
    p_inst  = if_inst;
    p_rdy   = rdy;
    p_fire  = mem_ack && rdy;
    @(posedge clk);
    if (p_rdy) begin
      if (br_taken) begin
        exp_pc = {br_target[31:2], 2'b00};
      end else if (p_valid && !stall[0]) begin
        exp_pc = p_pc + 32'd4;
        presented++;
      end
    end
    @(negedge clk);
    verify();
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b0; stall = '0; br_taken = 1'b0; br_target = '0;
    mem_ack = 1'b0; mem_rdata = '0; auto_mem = 1'b0; wait_cnt = 0;
    lat_lo = 0; lat_hi = 0; exp_pc = 32'h0;

    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    repeat (2) tick();
    chk("idle_no_req", 32'(mem_req), 32'd0);

    // Zero-wait fetches: addresses 0,4,8 with if_valid every 2nd cycle
    rdy = 1'b1; auto_mem = 1'b1;
    tick(); chk("seq_addr0", mem_addr, 32'h0); chk("seq_req0", 32'(mem_req), 32'd1);
    tick(); chk("seq_valid0", 32'(if_valid), 32'd1); chk("seq_inst0", if_inst, word_of(32'h0));
    tick(); chk("seq_addr4", mem_addr, 32'h4); chk("seq_bubble", 32'(if_valid), 32'd0);
    tick(); chk("seq_valid4", 32'(if_valid), 32'd1); chk("seq_pc4", if_pc, 32'h4);
    tick(); chk("seq_addr8", mem_addr, 32'h8);

    // Redirect to 0x100 while fetching 0x8 with a delayed ack
    auto_mem = 1'b0; br_taken = 1'b1; br_target = 32'h100;
    tick(); br_taken = 1'b0;
    chk("drop_addr", mem_addr, 32'h8);
    repeat (2) tick();
    chk("drop_addr_hold", mem_addr, 32'h8);
    mem_ack = 1'b1; mem_rdata = word_of(32'h8);
    tick(); mem_ack = 1'b0;
    chk("drop_next_addr", mem_addr, 32'h100);
    chk("drop_no_valid", 32'(if_valid), 32'd0);
    auto_mem = 1'b1; wait_cnt = 0;
    tick(); chk("tgt_pc", if_pc, 32'h100);

    // Hold in READY under stall[0]
    stall = 5'b00001;
    repeat (5) begin
      tick();
      chk("stall_pc", if_pc, 32'h100);
      chk("stall_req_low", 32'(mem_req), 32'd0);
    end
    stall = '0;
    tick(); chk("stall_release_addr", mem_addr, 32'h104);

    // Redirect coincident with ack, unaligned target
    br_taken = 1'b1; br_target = 32'h203;
    tick(); br_taken = 1'b0;
    chk("coinc_addr", mem_addr, 32'h200);
    chk("coinc_no_valid", 32'(if_valid), 32'd0);
    tick(); chk("coinc_pc", if_pc, 32'h200);
    tick(); chk("coinc_next", mem_addr, 32'h204);

    // Two redirects while in DROP: latest wins
    auto_mem = 1'b0; mem_ack = 1'b0;
    br_taken = 1'b1; br_target = 32'h40;
    tick(); chk("dd_addr1", mem_addr, 32'h204);
    br_target = 32'h80;
    tick(); br_taken = 1'b0; chk("dd_addr2", mem_addr, 32'h204);
    mem_ack = 1'b1; mem_rdata = word_of(32'h204);
    tick(); mem_ack = 1'b0;
    chk("dd_target", mem_addr, 32'h80);
    auto_mem = 1'b1; wait_cnt = 0;
    tick(); chk("dd_pc", if_pc, 32'h80);

    // rdy low in READY: nothing moves
    rdy = 1'b0;
    repeat (4) begin
      tick();
      chk("rdy_pc", if_pc, 32'h80);
      chk("rdy_valid", 32'(if_valid), 32'd1);
    end
    rdy = 1'b1;
    tick(); chk("rdy_resume_addr", mem_addr, 32'h84);

    // Asynchronous reset mid-FETCH, checked between clock edges
    #2 rst = 1'b0;
    #1 check_reset_values("async");
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b0; wait_cnt = 0; exp_pc = 32'h0;
    tick(); chk("post_reset_addr", mem_addr, 32'h0);

    // Randomized traffic against the model
    lat_lo = 0; lat_hi = 3;
    repeat (3000) begin
      rdy       = ($urandom_range(9, 0) != 0);
      stall     = 5'($urandom);
      stall[0]  = ($urandom_range(2, 0) == 0);
      br_taken  = rdy && ($urandom_range(11, 0) == 0);
      br_target = $urandom;
      tick();
    end
    br_taken = 1'b0;
    chk("liveness", 32'(presented > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage directly upstream of `IF_ID`. It owns the program counter and issues word fetches to the memory controller over a req/ack handshake. It holds the fetched word until the pipeline accepts it, then presents `if_pc`/`if_inst` to `IF_ID` together with a stall request. It also applies branch/jump redirects from EX, discarding any fetch already in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `rdy`  in  1  global enable; 0 freezes all state
- `stall`  in  5  pipeline stall vector; `stall[0]`=1 means IF must hold its output
- `br_taken`  in  1  one-cycle redirect strobe from EX
- `br_target`  in  32  redirect PC
- `mem_req`  out  1  fetch request, held until `mem_ack`
- `mem_addr`  out  32  fetch address, stable while `mem_req`=1
- `mem_ack`  in  1  one-cycle pulse, `mem_rdata` valid
- `mem_rdata`  in  32  fetched word
- `if_pc`  out  32  PC of presented instruction
- `if_inst`  out  32  presented instruction; 0 when `if_valid`=0
- `if_valid`  out  1  `if_pc`/`if_inst` hold a real instruction
- `stall_req`  out  1  IF cannot supply an instruction this cycle

## Operation
- States: IDLE, FETCH, READY, DROP. Every output is decoded from registers only; there is no combinational input-to-output path.
- IDLE: reset state. Moves to FETCH on the first cycle with `rdy`=1.
- FETCH: `mem_req`=1, `mem_addr`=pc.
  - On `mem_ack`, buffer `mem_rdata` and move to READY.
- READY: `if_valid`=1, `if_pc`=pc, `if_inst`=buffer.
  - If `stall[0]`=0 at an edge, the word is consumed: pc<=pc+4 (modulo 2^32) and the state moves to FETCH.
  - If `stall[0]`=1, hold everything.
- DROP: `mem_req`=1 with the old address until `mem_ack`. The returned data is discarded and the state moves to FETCH using the current pc.
- Redirect (`br_taken`=1) has priority over stall and consume. pc<=`{br_target[31:2],2'b00}`.
  - IDLE/READY: discard the buffer and go to FETCH.
  - FETCH without ack: go to DROP (the request cannot be withdrawn).
  - FETCH with ack in the same cycle: discard the data and go to FETCH.
  - DROP: update pc (latest redirect wins) and stay in DROP; if ack arrives in the same cycle, go to FETCH.
- `stall_req`=1 in every state except READY.
- `if_inst`=0 and `if_pc`=0 whenever `if_valid`=0, so a bubble decodes as a nop.

## Timing
- Reset values (while `rst`=0):
  - state=IDLE, pc=`RESET_PC`
  - `mem_req`=0, `mem_addr`=`RESET_PC`
  - `if_pc`=0, `if_inst`=0, `if_valid`=0, `stall_req`=1
- Reset asserted mid-fetch aborts immediately. The controller sees `mem_req` drop and must abandon the request.
- `mem_req` rises one cycle after leaving IDLE or after consumption.
- `mem_ack` at edge t gives `if_valid`=1 from t+1.
- Zero-wait-state memory sustains 1 instruction per 2 cycles.
- `rdy`=0: no state changes. The memory controller is frozen by the same `rdy`, so `mem_ack` never pulses while `rdy`=0.
- `mem_ack` is ignored in IDLE and READY.
- A redirect takes effect at the edge where it is sampled. The first fetch of the target issues the next cycle, or after the pending ack when in DROP.

## Structure
- `defines.v` gains the IF state encodings (`IfIdle`, `IfFetch`, `IfReady`, `IfDrop`) and `ResetPc`.
- Reuse `InstAddrBus`, `InstBus`, `ZeroWord` and `True_v`/`False_v` from `defines.v`.
- One sub-module, `pc_gen`: the pc register, the +4 and redirect mux, and target alignment.
- FSM, buffer and output decode stay in `inst_fetch`.

## Test plan
- Reset release, `RESET_PC`=0, ack 1 cycle after each req, `stall`=0:
  - `mem_addr` sequence 0,4,8.
  - `if_inst` equals `mem_rdata`, with `if_valid` pulsing every 2nd cycle.
- READY with `stall[0]`=1 for 5 cycles:
  - `if_pc`/`if_inst` stay constant, `mem_req`=0.
  - Release → next `mem_addr`=pc+4.
- `br_taken` with target 0x100 while FETCH at 0x8 with ack delayed 3 cycles:
  - `mem_addr` stays 0x8 until the ack; that data never appears on `if_inst`.
  - The next request goes to 0x100.
- `br_taken` coincident with `mem_ack` at 0xC, target 0x203:
  - The data is dropped; the next `mem_addr`=0x200.
- Two redirects (0x40, then 0x80) while in DROP:
  - After the ack, the fetch goes to 0x80.
- Async reset pulled low mid-FETCH, and `rdy`=0 for 4 cycles in READY:
  - Reset: outputs reach reset values without waiting for a clock edge.
  - `rdy`=0: no output changes while it is low.
